// File: rtl/key_repeat.sv
// Button event generator: turns a debounced button level into one-cycle press,
// auto-repeat and release strobes, a held level and a saturating repeat count.
module key_repeat #(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned FIRST_DELAY   = 5000000,
  parameter int unsigned REPEAT_PERIOD = 1000000
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       bin,
  input  logic       enable,
  output logic       pulse,
  output logic       press,
  // "release" is a reserved word in SystemVerilog, hence the suffix
  output logic       release_pulse,
  output logic       held,
  output logic [7:0] rep_count
);

  localparam int unsigned REP_W = 8;
  localparam logic [CNT_W-1:0] FIRST_LAST  = CNT_W'(FIRST_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_MAX     = {REP_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [REP_W-1:0] rep_d, rep_inc;
  logic             bin_q;
  logic             press_d, pulse_d, release_d;

  assign rep_inc = (rep_count == REP_MAX) ? rep_count : rep_count + REP_W'(1);

  // State register plus registered outputs
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      bin_q         <= 1'b0;
      rep_count     <= '0;
      press         <= 1'b0;
      pulse         <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      bin_q         <= bin;
      rep_count     <= rep_d;
      press         <= press_d;
      pulse         <= pulse_d;
      release_pulse <= release_d;
      held          <= (state_d != IDLE);
    end
  end

  // Next state; release outranks enable, which outranks timer expiry
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rep_d     = rep_count;
    press_d   = 1'b0;
    pulse_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (bin_q) begin
          state_d = WAIT;
          rep_d   = '0;
          press_d = 1'b1;
          pulse_d = 1'b1;
        end
      end
      WAIT: begin
        if (!bin_q) begin
          release_d = 1'b1;
          state_d   = IDLE;
          timer_d   = '0;
        end else if (!enable) begin
          timer_d = '0;
        end else if (timer_q == FIRST_LAST) begin
          pulse_d = 1'b1;
          rep_d   = rep_inc;
          timer_d = '0;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!bin_q) begin
          release_d = 1'b1;
          state_d   = IDLE;
          timer_d   = '0;
        end else if (!enable) begin
          timer_d = '0;
          state_d = WAIT;
        end else if (timer_q == REPEAT_LAST) begin
          pulse_d = 1'b1;
          rep_d   = rep_inc;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_repeat.sv
// Scoreboard bench for key_repeat: a cycle-count reference model predicts the
// outputs after every clock edge and a monitor compares them against the DUT.
module tb_key_repeat;

  localparam int FD = 10;
  localparam int RP = 4;

  logic       m_clock = 1'b0;
  logic       p_reset = 1'b1;
  logic       bin     = 1'b0;
  logic       enable  = 1'b1;
  logic       pulse, press, release_pulse, held;
  logic [7:0] rep_count;

  key_repeat #(.CNT_W(24), .FIRST_DELAY(FD), .REPEAT_PERIOD(RP)) dut (
    .m_clock       (m_clock),
    .p_reset       (p_reset),
    .bin           (bin),
    .enable        (enable),
    .pulse         (pulse),
    .press         (press),
    .release_pulse (release_pulse),
    .held          (held),
    .rep_count     (rep_count)
  );

  always #5 m_clock = ~m_clock;

  typedef struct packed {
    logic       press;
    logic       pulse;
    logic       rel;
    logic       held;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference: a hold is a run of enabled cycles counted from the press (or from
  // the last cycle enable was low); repeats fire at run FD, FD+RP, FD+2RP, ...
  bit m_bq   = 1'b0;
  bit m_hold = 1'b0;
  int m_run  = 0;
  int m_reps = 0;

  always @(posedge m_clock) begin
    obs_t e;
    e = '0;
    if (p_reset) begin
      m_hold = 1'b0;
      m_run  = 0;
      m_reps = 0;
    end else if (!m_hold) begin
      if (m_bq) begin
        e.press = 1'b1;
        e.pulse = 1'b1;
        m_hold  = 1'b1;
        m_run   = 0;
        m_reps  = 0;
      end
    end else if (!m_bq) begin
      e.rel  = 1'b1;
      m_hold = 1'b0;
    end else if (!enable) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == FD || (m_run > FD && (m_run - FD) % RP == 0)) begin
        e.pulse = 1'b1;
        if (m_reps < 255) m_reps++;
      end
    end
    e.held = m_hold;
    e.cnt  = 8'(m_reps);
    m_bq   = p_reset ? 1'b0 : bin;
    exp_q.push_back(e);
  end

  // Monitor: sample just after each edge and check against the oldest prediction
  always @(posedge m_clock) begin
    obs_t got, e;
    #1;
    cyc++;
    got = {press, pulse, release_pulse, held, rep_count};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty cycle %0d: got %h, no prediction queued", cyc, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        fails++;
        $display("FAIL outputs cycle %0d: got press=%b pulse=%b release=%b held=%b cnt=%0d, want press=%b pulse=%b release=%b held=%b cnt=%0d",
                 cyc, got.press, got.pulse, got.rel, got.held, got.cnt,
                 e.press, e.pulse, e.rel, e.held, e.cnt);
      end
    end
  end

  task automatic step(input logic b, input logic en, input logic r);
    @(negedge m_clock);
    bin     = b;
    enable  = en;
    p_reset = r;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic hold(input int n, input logic en);
    repeat (n) step(1'b1, en, 1'b0);
  endtask

  initial begin
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    idle(3);
    hold(5, 1'b1);                 idle(4);   // press and release, no repeat
    hold(30, 1'b1);                idle(4);   // auto-repeat
    hold(FD, 1'b1);                idle(4);   // release lands on first expiry
    hold(FD + RP, 1'b1);           idle(4);   // release lands on repeat expiry
    hold(20, 1'b0); hold(20, 1'b1); idle(4);  // enable gating
    hold(12, 1'b1); hold(3, 1'b0); hold(15, 1'b1); idle(4); // disable in REPEAT
    hold(FD + RP * 300 + 8, 1'b1); idle(4);   // counter saturation
    hold(25, 1'b1); step(1'b1, 1'b1, 1'b1); hold(20, 1'b1); idle(4); // reset mid-hold
    hold(1, 1'b1);                 idle(4);   // single-sample press
    for (int i = 0; i < 60; i++) begin
      int len;
      len = int'($urandom_range(1, 45));
      for (int j = 0; j < len; j++) begin
        logic en, r;
        en = ($urandom_range(0, 9) != 0);
        r  = ($urandom_range(0, 199) == 0);
        step(1'b1, en, r);
      end
      idle(int'($urandom_range(1, 6)));
    end
    idle(4);
    @(negedge m_clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time, got %0d cycles", cyc);
    $fatal(1, "timeout");
  end

endmodule
